rift2_wb_master: RTL and testbench
==================================

# rift2_wb_master

Wishbone classic (B4, non-pipelined) bus master for the rift2 user project: converts a single-outstanding valid/ready request from the core's uncached load/store path into one Wishbone cycle and returns a buffered response. It is the initiator counterpart of the management-SoC slave port on `user_project_wrapper`, and it drives a Wishbone interconnect inside `rift2Wrap`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; `DW/8` byte selects
- `TIMEOUT`, 255, BUS-state cycles without termination before abort (used only with `RIFT2_WB_TIMEOUT_EN`)

- `wb_clk_i` in 1: the single clock
- `wb_rst_n_i` in 1: reset, asynchronous, active-low
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake
- `req_we_i` in 1: 1 = write
- `req_addr_i` in AW, `req_wdata_i` in DW, `req_sel_i` in DW/8: request payload
- `rsp_valid_o` out 1 / `rsp_ready_i` in 1: response handshake
- `rsp_rdata_o` out DW: read data (0 for writes and errors)
- `rsp_err_o` out 1: bus error or timeout
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1; `wbm_adr_o` out AW; `wbm_dat_o` out DW; `wbm_sel_o` out DW/8
- `wbm_dat_i` in DW; `wbm_ack_i`, `wbm_err_i` in 1

## Operation
- FSM states: IDLE, BUS, RESP; all outputs registered.
- IDLE: `req_ready_o`=1. On `req_valid_i & req_ready_o`, latch we/addr/wdata/sel, go to BUS.
- BUS: `wbm_cyc_o`=`wbm_stb_o`=1, payload held stable from the latched values. `wbm_dat_o` is driven with the latched wdata on writes and 0 on reads.
- On `wbm_err_i`, go to RESP with `rsp_err_o`=1 and `rsp_rdata_o`=0. If `wbm_err_i` and `wbm_ack_i` are both high, err takes priority.
- On `wbm_ack_i` alone, capture `wbm_dat_i` (reads only; writes return 0) and go to RESP with `rsp_err_o`=0.
- RESP: cyc/stb low, `rsp_valid_o`=1, data and err held until `rsp_ready_i`, then go to IDLE.
- `wbm_ack_i`/`wbm_err_i` outside BUS are ignored.
- Address and sel pass through unmodified; no alignment checking.
- Only one transaction is outstanding; `req_ready_o`=0 in BUS and RESP.

## Timing
- Reset values (async assert, sync-released use): state IDLE, `req_ready_o`=1 after reset release, all `wbm_*_o`=0, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0.
- Request accepted at edge N → cyc/stb high from N to the termination edge M.
- Termination sampled at edge M → cyc/stb low and `rsp_valid_o` high after M. There is exactly one ack per cycle.
- Response consumed at edge R → `req_ready_o` high after R. Zero-wait-state slave: 3 cycles per transaction.
- Reset asserted mid-transaction: cyc/stb drop immediately and the transaction is discarded with no response.

## Configuration
- `RIFT2_WB_TIMEOUT_EN` defined: an 8..16-bit counter clears on entry to BUS and increments each BUS cycle without termination. When it reaches `TIMEOUT`, cyc/stb drop on that edge and the block goes to RESP with `rsp_err_o`=1 and `rsp_rdata_o`=0. A termination arriving on the same edge as expiry takes precedence over the timeout.
- Not defined: no counter; BUS waits indefinitely for ack/err.

## Structure
- Package `rift2_wb_pkg`: FSM state enum, default `AW`/`DW`, sel width derivation, timeout counter width constant.
- One sub-module, `rift2_wb_timeout`: a clear/enable/expire counter, instantiated only under `RIFT2_WB_TIMEOUT_EN`.

## Test plan
- Read, slave acks after 2 wait states with `wbm_dat_i`=0xDEADBEEF → `rsp_rdata_o`=0xDEADBEEF, `rsp_err_o`=0, cyc high exactly 3 cycles.
- Write addr 0x3000_0004, data 0x1234_5678, sel 0b0011 → bus shows exactly those values with `wbm_we_o`=1; response has `rsp_rdata_o`=0.
- ack and err asserted together → `rsp_err_o`=1, `rsp_rdata_o`=0; stray ack in IDLE → no response.
- `rsp_ready_i` held low 5 cycles → response held stable, `req_ready_o`=0, new `req_valid_i` not accepted.
- With `RIFT2_WB_TIMEOUT_EN` and `TIMEOUT`=8, slave never responds → cyc drops after 8 BUS cycles and `rsp_err_o`=1. Without the macro → cyc stays high for 1000 cycles.
- `wb_rst_n_i` pulsed low mid-BUS → all `wbm_*_o`=0 asynchronously and no `rsp_valid_o`; the next request completes normally.

Source files
------------

// File: rtl/rift2_wb_pkg.sv
// Shared types and defaults for the rift2 Wishbone master.
// The optional bus watchdog is selected with the RIFT2_WB_TIMEOUT_EN macro.
package rift2_wb_pkg;

   localparam int unsigned WB_AW_DEF   = 32;
   localparam int unsigned WB_DW_DEF   = 32;
   localparam int unsigned WB_TO_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } wb_state_e;

   function automatic int unsigned wb_sel_w(input int unsigned dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/rift2_wb_timeout.sv
// Clear/enable/expire counter bounding how long a Wishbone cycle may stay open.
// Instantiated by rift2_wb_master only when RIFT2_WB_TIMEOUT_EN is defined.
module rift2_wb_timeout
   import rift2_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CW      = WB_TO_CNT_W
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + CW'(1);
   // Expiry fires on the edge at which the count would reach TIMEOUT.
   assign o_expire  = i_en && (w_cnt_nxt == CW'(TIMEOUT));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/rift2_wb_master.sv
// Single-outstanding valid/ready request to Wishbone B4 classic master, registered outputs.
// Define RIFT2_WB_TIMEOUT_EN to abort cycles that are not terminated within TIMEOUT cycles.
module rift2_wb_master
   import rift2_wb_pkg::*;
#(
   parameter int unsigned AW      = WB_AW_DEF,
   parameter int unsigned DW      = WB_DW_DEF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_n_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [AW-1:0]   req_addr_i,
   input  logic [DW-1:0]   req_wdata_i,
   input  logic [DW/8-1:0] req_sel_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_rdata_o,
   output logic            rsp_err_o,
   output logic            wbm_cyc_o,
   output logic            wbm_stb_o,
   output logic            wbm_we_o,
   output logic [AW-1:0]   wbm_adr_o,
   output logic [DW-1:0]   wbm_dat_o,
   output logic [DW/8-1:0] wbm_sel_o,
   input  logic [DW-1:0]   wbm_dat_i,
   input  logic            wbm_ack_i,
   input  logic            wbm_err_i
);

   localparam int unsigned SW = wb_sel_w(DW);

   wb_state_e     r_state, w_state_nxt;
   logic          r_req_ready, w_req_ready_nxt;
   logic          r_cyc, w_cyc_nxt;
   logic          r_we, w_we_nxt;
   logic [AW-1:0] r_adr, w_adr_nxt;
   logic [DW-1:0] r_dat, w_dat_nxt;
   logic [SW-1:0] r_sel, w_sel_nxt;
   logic          r_rsp_valid, w_rsp_valid_nxt;
   logic [DW-1:0] r_rdata, w_rdata_nxt;
   logic          r_err, w_err_nxt;
   logic          w_expire;

`ifdef RIFT2_WB_TIMEOUT_EN
   logic w_to_clr;
   logic w_to_en;

   assign w_to_clr = (r_state == ST_IDLE) && req_valid_i;
   assign w_to_en  = (r_state == ST_BUS) && !wbm_ack_i && !wbm_err_i;

   rift2_wb_timeout #(
      .TIMEOUT (TIMEOUT),
      .CW      (WB_TO_CNT_W)
   ) u_timeout (
      .i_clk    (wb_clk_i),
      .i_rst_n  (wb_rst_n_i),
      .i_clr    (w_to_clr),
      .i_en     (w_to_en),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_req_ready_nxt = r_req_ready;
      w_cyc_nxt       = r_cyc;
      w_we_nxt        = r_we;
      w_adr_nxt       = r_adr;
      w_dat_nxt       = r_dat;
      w_sel_nxt       = r_sel;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rdata_nxt     = r_rdata;
      w_err_nxt       = r_err;
      unique case (r_state)
         ST_IDLE: begin
            if (req_valid_i) begin
               w_state_nxt     = ST_BUS;
               w_req_ready_nxt = 1'b0;
               w_cyc_nxt       = 1'b1;
               w_we_nxt        = req_we_i;
               w_adr_nxt       = req_addr_i;
               w_dat_nxt       = req_we_i ? req_wdata_i : '0;
               w_sel_nxt       = req_sel_i;
            end
         end
         ST_BUS: begin
            if (wbm_err_i || wbm_ack_i || w_expire) begin
               w_state_nxt     = ST_RESP;
               w_cyc_nxt       = 1'b0;
               w_we_nxt        = 1'b0;
               w_adr_nxt       = '0;
               w_dat_nxt       = '0;
               w_sel_nxt       = '0;
               w_rsp_valid_nxt = 1'b1;
               // Error wins over ack; a bare expiry (no ack) is also an error.
               w_err_nxt       = wbm_err_i || !wbm_ack_i;
               w_rdata_nxt     = (wbm_ack_i && !wbm_err_i && !r_we) ? wbm_dat_i : '0;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               w_state_nxt     = ST_IDLE;
               w_req_ready_nxt = 1'b1;
               w_rsp_valid_nxt = 1'b0;
               w_rdata_nxt     = '0;
               w_err_nxt       = 1'b0;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_req_ready_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state     <= ST_IDLE;
         r_req_ready <= 1'b1;
         r_cyc       <= 1'b0;
         r_we        <= 1'b0;
         r_adr       <= '0;
         r_dat       <= '0;
         r_sel       <= '0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_cyc       <= w_cyc_nxt;
         r_we        <= w_we_nxt;
         r_adr       <= w_adr_nxt;
         r_dat       <= w_dat_nxt;
         r_sel       <= w_sel_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rdata     <= w_rdata_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign req_ready_o = r_req_ready;
   assign wbm_cyc_o   = r_cyc;
   assign wbm_stb_o   = r_cyc;
   assign wbm_we_o    = r_we;
   assign wbm_adr_o   = r_adr;
   assign wbm_dat_o   = r_dat;
   assign wbm_sel_o   = r_sel;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rdata;
   assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_rift2_wb_master.sv
// Randomized bench for rift2_wb_master: the bench plays the Wishbone slave and the requester.
// Covers the RIFT2_WB_TIMEOUT_EN build as well as the default build.
module tb_rift2_wb_master;

   localparam int AW         = 32;
   localparam int DW         = 32;
   localparam int SW         = DW / 8;
   localparam int TB_TIMEOUT = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [SW-1:0] req_sel = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          cyc, stb, we_o;
   logic [AW-1:0] adr_o;
   logic [DW-1:0] dat_o;
   logic [SW-1:0] sel_o;
   logic [DW-1:0] s_dat = '0;
   logic          s_ack = 1'b0;
   logic          s_err = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rift2_wb_master #(.AW(AW), .DW(DW), .TIMEOUT(TB_TIMEOUT)) u_dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_sel_i   (req_sel),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .wbm_cyc_o   (cyc),
      .wbm_stb_o   (stb),
      .wbm_we_o    (we_o),
      .wbm_adr_o   (adr_o),
      .wbm_dat_o   (dat_o),
      .wbm_sel_o   (sel_o),
      .wbm_dat_i   (s_dat),
      .wbm_ack_i   (s_ack),
      .wbm_err_i   (s_err)
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Presents one request for a single edge, then scrambles the payload lines.
   task automatic start_req(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [SW-1:0] sel);
      @(negedge clk);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_sel   = sel;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_sel   = SW'($urandom);
   endtask

   // Called at a negedge with a response pending; holds it rdly cycles, then consumes it.
   task automatic consume(input int rdly, input logic exp_err, input logic [DW-1:0] exp_dat);
      for (int i = 0; i < rdly; i++) begin
         req_valid = 1'b1;
         @(negedge clk);
         check("hold_valid", rsp_valid, 1);
         check("hold_err", rsp_err, exp_err);
         check("hold_rdata", rsp_rdata, exp_dat);
         check("hold_ready", req_ready, 0);
         check("hold_cyc", {cyc, stb}, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("rsp_done_valid", rsp_valid, 0);
      check("rsp_done_ready", req_ready, 1);
      check("rsp_done_cyc", cyc, 0);
   endtask

   // kind: 0 = ack, 1 = err, 2 = ack and err together.
   task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] sel, input int waits, input int kind,
                          input logic [DW-1:0] rdat, input int rdly);
      logic          exp_err;
      logic [DW-1:0] exp_dat;
      exp_err = (kind != 0);
      exp_dat = (!exp_err && !we) ? rdat : {DW{1'b0}};
      start_req(we, addr, wdata, sel);
      for (int i = 0; i <= waits; i++) begin
         @(negedge clk);
         check("bus", {cyc, stb, we_o, adr_o, dat_o, sel_o},
               {1'b1, 1'b1, we, addr, (we ? wdata : {DW{1'b0}}), sel});
         check("bus_ready", req_ready, 0);
         check("bus_rspv", rsp_valid, 0);
         if (i == waits) begin
            s_ack = (kind != 1);
            s_err = (kind != 0);
            s_dat = rdat;
         end else begin
            s_dat = $urandom;
         end
      end
      @(posedge clk);
      #1;
      s_ack = 1'b0;
      s_err = 1'b0;
      s_dat = $urandom;
      @(negedge clk);
      check("term_cyc", {cyc, stb}, 0);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_rdata", rsp_rdata, exp_dat);
      check("rsp_ready_busy", req_ready, 0);
      consume(rdly, exp_err, exp_dat);
   endtask

   initial begin
      int hi_cnt;
      // Reset state
      #1;
      check("rst_wbm", {cyc, stb, we_o, adr_o, dat_o, sel_o}, 0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ready", req_ready, 1);
      check("rel_wbm", {cyc, stb, we_o, adr_o, dat_o, sel_o}, 0);
      check("rel_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);

      // Directed cases
      run_txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, 2, 0, 32'hDEAD_BEEF, 0);
      run_txn(1'b1, 32'h3000_0004, 32'h1234_5678, 4'b0011, 0, 0, 32'hCAFE_F00D, 0);
      run_txn(1'b0, 32'h2000_0010, 32'h0, 4'hF, 1, 2, 32'hA5A5_A5A5, 0);
      run_txn(1'b0, 32'h2000_0014, 32'h0, 4'h1, 0, 1, 32'h5555_AAAA, 5);

      // Stray ack/err while idle
      @(negedge clk);
      s_ack = 1'b1;
      s_err = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_rspv", rsp_valid, 0);
         check("stray_cyc", cyc, 0);
         check("stray_ready", req_ready, 1);
      end
      s_ack = 1'b0;
      s_err = 1'b0;

      // Randomized transactions
      for (int t = 0; t < 30; t++) begin
         run_txn(1'($urandom), $urandom, $urandom, SW'($urandom),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                 $urandom, int'($urandom_range(0, 3)));
      end

      // Unresponsive slave
      start_req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
`ifdef RIFT2_WB_TIMEOUT_EN
      for (int i = 0; i < TB_TIMEOUT; i++) begin
         @(negedge clk);
         check("to_cyc_high", {cyc, stb}, 2'b11);
         s_dat = $urandom;
      end
      @(negedge clk);
      check("to_cyc_low", {cyc, stb}, 0);
      check("to_rspv", rsp_valid, 1);
      check("to_err", rsp_err, 1);
      check("to_rdata", rsp_rdata, 0);
      consume(1, 1'b1, {DW{1'b0}});
`else
      hi_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (cyc && stb && !rsp_valid) hi_cnt++;
      end
      check("no_timeout", hi_cnt, 1000);
      s_ack = 1'b1;
      s_dat = 32'h0BAD_0BAD;
      @(posedge clk);
      #1;
      s_ack = 1'b0;
      @(negedge clk);
      check("late_ack_rspv", rsp_valid, 1);
      check("late_ack_rdata", rsp_rdata, 32'h0BAD_0BAD);
      consume(0, 1'b0, 32'h0BAD_0BAD);
`endif

      // Reset pulsed in the middle of a bus cycle
      start_req(1'b1, 32'h5000_0008, 32'hFFFF_0000, 4'b1100);
      @(negedge clk);
      check("pre_rst_cyc", cyc, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_wbm", {cyc, stb, we_o, adr_o, dat_o, sel_o}, 0);
      check("async_rst_rspv", rsp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_rspv", rsp_valid, 0);
         check("post_rst_cyc", cyc, 0);
         check("post_rst_ready", req_ready, 1);
      end
      run_txn(1'b0, 32'h5000_000C, 32'h0, 4'hF, 1, 0, 32'h7777_1111, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
